// File: rtl/otter_cu_pkg.sv
// Shared types and constants for the multi-cycle OTTER control unit.
// Holds opcode, SYSTEM funct3 and FSM state encodings plus the MRET pattern.
package otter_cu_pkg;

  typedef enum logic [6:0] {
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    BRANCH = 7'b1100011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    OP_IMM = 7'b0010011,
    OP     = 7'b0110011,
    SYSTEM = 7'b1110011,
    ENCRY  = 7'b0011100
  } opcode_t;

  typedef enum logic [2:0] {
    F3_PRIV   = 3'b000,
    F3_CSRRW  = 3'b001,
    F3_CSRRS  = 3'b010,
    F3_CSRRC  = 3'b011,
    F3_RSVD   = 3'b100,
    F3_CSRRWI = 3'b101,
    F3_CSRRSI = 3'b110,
    F3_CSRRCI = 3'b111
  } funct3_system_t;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_EXECUTE = 3'd1,
    ST_CRYPTO  = 3'd2,
    ST_WB      = 3'd3,
    ST_INTER   = 3'd4
  } cu_state_t;

  localparam logic [11:0] MRET_FUNC12 = 12'h302;

  // True for the six Zicsr variants (register and immediate forms).
  function automatic logic is_csr_func3(input logic [2:0] f3);
    funct3_system_t f;
    f = funct3_system_t'(f3);
    return (f != F3_PRIV) && (f != F3_RSVD);
  endfunction

endpackage

// File: rtl/otter_cu_round_ctr.sv
// Saturating round counter for the CRYPTO state, with a last-round flag
// for fixed-length mode.
module otter_cu_round_ctr
  import otter_cu_pkg::*;
#(
  parameter int CRYPTO_ROUNDS = 4,
  parameter int CNT_W         = 3
) (
  input  logic             CU_CLK,
  input  logic             CU_RESET_N,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] round,
  output logic             last
);

  always_ff @(posedge CU_CLK or negedge CU_RESET_N) begin
    if (!CU_RESET_N) begin
      round <= '0;
    end else if (clr) begin
      round <= '0;
    end else if (en && (round != '1)) begin
      round <= round + 1'b1;
    end
  end

  assign last = (round == CNT_W'(CRYPTO_ROUNDS - 1));

endmodule

// File: rtl/otter_cu_fsm_mc.sv
// Multi-cycle OTTER control unit: FETCH/EXECUTE/WB/INTER plus a CRYPTO state
// that runs ENCRY for a fixed round count or until the coprocessor reports done.
module otter_cu_fsm_mc
  import otter_cu_pkg::*;
#(
  parameter int CRYPTO_ROUNDS    = 4,
  parameter int CNT_W            = 3,
  parameter bit CRYPTO_HANDSHAKE = 1'b0
) (
  input  logic             CU_CLK,
  input  logic             CU_RESET_N,
  input  logic             CU_INT,
  input  logic             CU_prevINT,
  input  logic [6:0]       CU_OPCODE,
  input  logic [2:0]       CU_FUNC3,
  input  logic [11:0]      CU_FUNC12,
  input  logic             CU_CRYPTO_DONE,
  output logic             CU_PCWRITE,
  output logic             CU_REGWRITE,
  output logic             CU_MEMWRITE,
  output logic             CU_MEMREAD1,
  output logic             CU_MEMREAD2,
  output logic             CU_intTaken,
  output logic             CU_csrWrite,
  output logic             CU_intCLR,
  output logic             CU_CRYPTO_START,
  output logic [CNT_W-1:0] CU_CRYPTO_ROUND,
  output logic             CU_BUSY
);

  cu_state_t state;
  opcode_t   opc;
  logic      intp;
  logic      is_mret;
  logic      is_csr;
  logic      ctr_last;
  logic      crypto_last;
  cu_state_t retire_next;

  assign opc         = opcode_t'(CU_OPCODE);
  assign intp        = CU_INT | CU_prevINT;
  assign is_mret     = (opc == SYSTEM) && (CU_FUNC3 == 3'b000) && (CU_FUNC12 == MRET_FUNC12);
  assign is_csr      = (opc == SYSTEM) && is_csr_func3(CU_FUNC3);
  assign retire_next = intp ? ST_INTER : ST_FETCH;

  // DONE only matters while in CRYPTO; outside it the state decode masks it.
  assign crypto_last = CRYPTO_HANDSHAKE ? CU_CRYPTO_DONE : ctr_last;

  otter_cu_round_ctr #(
    .CRYPTO_ROUNDS (CRYPTO_ROUNDS),
    .CNT_W         (CNT_W)
  ) u_round_ctr (
    .CU_CLK     (CU_CLK),
    .CU_RESET_N (CU_RESET_N),
    .clr        ((state == ST_EXECUTE) && (opc == ENCRY)),
    .en         (state == ST_CRYPTO),
    .round      (CU_CRYPTO_ROUND),
    .last       (ctr_last)
  );

  always_ff @(posedge CU_CLK or negedge CU_RESET_N) begin
    if (!CU_RESET_N) begin
      state <= ST_FETCH;
    end else begin
      case (state)
        ST_FETCH:   state <= ST_EXECUTE;
        ST_EXECUTE: begin
          case (opc)
            LOAD:    state <= ST_WB;
            ENCRY:   state <= ST_CRYPTO;
            default: state <= retire_next;
          endcase
        end
        // Interrupts wait for the final CRYPTO cycle; no mid-operation exit.
        ST_CRYPTO:  if (crypto_last) state <= retire_next;
        ST_WB:      state <= retire_next;
        ST_INTER:   state <= ST_FETCH;
        default:    state <= ST_FETCH;
      endcase
    end
  end

  always_comb begin
    CU_PCWRITE      = 1'b0;
    CU_REGWRITE     = 1'b0;
    CU_MEMWRITE     = 1'b0;
    CU_MEMREAD1     = 1'b0;
    CU_MEMREAD2     = 1'b0;
    CU_intTaken     = 1'b0;
    CU_csrWrite     = 1'b0;
    CU_CRYPTO_START = 1'b0;
    CU_BUSY         = 1'b0;
    case (state)
      ST_FETCH: CU_MEMREAD1 = 1'b1;
      ST_EXECUTE: begin
        case (opc)
          LOAD:  CU_MEMREAD2 = 1'b1;
          STORE: begin
            CU_MEMWRITE = 1'b1;
            CU_PCWRITE  = 1'b1;
          end
          ENCRY:  CU_CRYPTO_START = 1'b1;
          BRANCH: CU_PCWRITE = 1'b1;
          SYSTEM: begin
            CU_PCWRITE  = 1'b1;
            CU_REGWRITE = !is_mret;
            CU_csrWrite = is_csr;
          end
          LUI, AUIPC, JAL, JALR, OP_IMM, OP: begin
            CU_PCWRITE  = 1'b1;
            CU_REGWRITE = 1'b1;
          end
          // Illegal opcode: skip the instruction without side effects.
          default: CU_PCWRITE = 1'b1;
        endcase
      end
      ST_CRYPTO: begin
        CU_BUSY = 1'b1;
        if (crypto_last) begin
          CU_PCWRITE  = 1'b1;
          CU_REGWRITE = 1'b1;
        end
      end
      ST_WB: begin
        CU_PCWRITE  = 1'b1;
        CU_REGWRITE = 1'b1;
      end
      ST_INTER: begin
        CU_intTaken = 1'b1;
        CU_PCWRITE  = 1'b1;
      end
      default: ;
    endcase
  end

  assign CU_intCLR = CU_PCWRITE;

endmodule

// File: tb/tb_otter_cu_fsm_mc.sv
// Bench for otter_cu_fsm_mc: a fixed-round and a handshake instance, each
// checked cycle by cycle against per-instruction expected strobe traces.
module tb_otter_cu_fsm_mc;

  localparam int ROUNDS = 4;
  localparam int CW     = 3;
  localparam int RMAX   = (1 << CW) - 1;

  localparam logic [9:0] V_PC    = 10'b1000000000;
  localparam logic [9:0] V_RW    = 10'b0100000000;
  localparam logic [9:0] V_MW    = 10'b0010000000;
  localparam logic [9:0] V_MR1   = 10'b0001000000;
  localparam logic [9:0] V_MR2   = 10'b0000100000;
  localparam logic [9:0] V_INT   = 10'b0000010000;
  localparam logic [9:0] V_CSR   = 10'b0000001000;
  localparam logic [9:0] V_CLR   = 10'b0000000100;
  localparam logic [9:0] V_START = 10'b0000000010;
  localparam logic [9:0] V_BUSY  = 10'b0000000001;

  localparam logic [6:0] O_LUI = 7'b0110111, O_AUIPC = 7'b0010111, O_JAL = 7'b1101111;
  localparam logic [6:0] O_JALR = 7'b1100111, O_BR = 7'b1100011, O_LOAD = 7'b0000011;
  localparam logic [6:0] O_STORE = 7'b0100011, O_OPI = 7'b0010011, O_OP = 7'b0110011;
  localparam logic [6:0] O_SYS = 7'b1110011, O_ENC = 7'b0011100;

  logic          CU_CLK = 1'b0;
  logic          CU_RESET_N = 1'b0;
  logic          CU_INT = 1'b0;
  logic          CU_prevINT = 1'b0;
  logic [6:0]    CU_OPCODE = 7'b0;
  logic [2:0]    CU_FUNC3 = 3'b0;
  logic [11:0]   CU_FUNC12 = 12'b0;
  logic          CU_CRYPTO_DONE = 1'b0;
  bit            sel = 1'b0;
  int            checks = 0;
  int            errors = 0;

  logic          pcw_f, rw_f, mw_f, mr1_f, mr2_f, it_f, csr_f, clr_f, st_f, busy_f;
  logic          pcw_h, rw_h, mw_h, mr1_h, mr2_h, it_h, csr_h, clr_h, st_h, busy_h;
  logic [CW-1:0] rnd_f, rnd_h;
  logic [9:0]    obs;
  logic [CW-1:0] obs_round;

  assign obs = sel ? {pcw_h, rw_h, mw_h, mr1_h, mr2_h, it_h, csr_h, clr_h, st_h, busy_h}
                   : {pcw_f, rw_f, mw_f, mr1_f, mr2_f, it_f, csr_f, clr_f, st_f, busy_f};
  assign obs_round = sel ? rnd_h : rnd_f;

  always #5 CU_CLK = ~CU_CLK;

  otter_cu_fsm_mc #(.CRYPTO_ROUNDS(ROUNDS), .CNT_W(CW), .CRYPTO_HANDSHAKE(1'b0)) dut_f (
    .CU_CLK(CU_CLK), .CU_RESET_N(CU_RESET_N), .CU_INT(CU_INT), .CU_prevINT(CU_prevINT),
    .CU_OPCODE(CU_OPCODE), .CU_FUNC3(CU_FUNC3), .CU_FUNC12(CU_FUNC12),
    .CU_CRYPTO_DONE(CU_CRYPTO_DONE), .CU_PCWRITE(pcw_f), .CU_REGWRITE(rw_f),
    .CU_MEMWRITE(mw_f), .CU_MEMREAD1(mr1_f), .CU_MEMREAD2(mr2_f), .CU_intTaken(it_f),
    .CU_csrWrite(csr_f), .CU_intCLR(clr_f), .CU_CRYPTO_START(st_f),
    .CU_CRYPTO_ROUND(rnd_f), .CU_BUSY(busy_f));

  otter_cu_fsm_mc #(.CRYPTO_ROUNDS(ROUNDS), .CNT_W(CW), .CRYPTO_HANDSHAKE(1'b1)) dut_h (
    .CU_CLK(CU_CLK), .CU_RESET_N(CU_RESET_N), .CU_INT(CU_INT), .CU_prevINT(CU_prevINT),
    .CU_OPCODE(CU_OPCODE), .CU_FUNC3(CU_FUNC3), .CU_FUNC12(CU_FUNC12),
    .CU_CRYPTO_DONE(CU_CRYPTO_DONE), .CU_PCWRITE(pcw_h), .CU_REGWRITE(rw_h),
    .CU_MEMWRITE(mw_h), .CU_MEMREAD1(mr1_h), .CU_MEMREAD2(mr2_h), .CU_intTaken(it_h),
    .CU_csrWrite(csr_h), .CU_intCLR(clr_h), .CU_CRYPTO_START(st_h),
    .CU_CRYPTO_ROUND(rnd_h), .CU_BUSY(busy_h));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut=%s got %h expected %h at %0t", tag, sel ? "hs" : "fixed", act, exp, $time);
    end
  endtask

  // Interrupt inputs: mode 1 forces a pending interrupt, 2 forces none, else random.
  task automatic pick(input int mode, output bit i, output bit pi);
    if (mode == 1) begin
      i = 1'b1; pi = 1'($urandom % 2);
    end else if (mode == 2) begin
      i = 1'b0; pi = 1'b0;
    end else begin
      i = ($urandom % 4) == 0; pi = ($urandom % 4) == 0;
    end
  endtask

  task automatic cyc(input string tag, input logic [9:0] e, input bit chk_r, input int er,
                     input bit i, input bit pi, input bit d);
    CU_INT = i; CU_prevINT = pi; CU_CRYPTO_DONE = d;
    @(negedge CU_CLK);
    check(tag, 32'(obs), 32'(e));
    if (chk_r) check({tag, "_round"}, 32'(obs_round), er);
    @(posedge CU_CLK);
    #1;
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {O_LUI, O_AUIPC, O_JAL, O_JALR, O_BR, O_LOAD, O_STORE,
                      O_OPI, O_OP, O_SYS, O_ENC};
  endfunction

  // One instruction from FETCH to its final cycle (INTER included when taken).
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [11:0] f12,
                           input int mode, input int done_k);
    bit i, pi, mret, csr;
    logic [9:0] e;
    int n;
    CU_OPCODE = op; CU_FUNC3 = f3; CU_FUNC12 = f12;
    mret = (op == O_SYS) && (f3 == 3'b000) && (f12 == 12'h302);
    csr  = (op == O_SYS) && (f3 != 3'b000) && (f3 != 3'b100);
    pick(mode, i, pi);
    cyc("fetch", V_MR1, 1'b0, 0, i, pi, 1'($urandom % 2));
    pick(mode, i, pi);
    if (op == O_LOAD) begin
      cyc("exec_load", V_MR2, 1'b0, 0, i, pi, 1'($urandom % 2));
      pick(mode, i, pi);
      cyc("wb", V_PC | V_RW | V_CLR, 1'b0, 0, i, pi, 1'($urandom % 2));
    end else if (op == O_STORE) begin
      cyc("exec_store", V_PC | V_MW | V_CLR, 1'b0, 0, i, pi, 1'($urandom % 2));
    end else if (op == O_ENC) begin
      cyc("exec_encry", V_START, 1'b0, 0, i, pi, 1'($urandom % 2));
      n = sel ? done_k + 1 : ROUNDS;
      for (int k = 0; k < n; k++) begin
        pick(mode, i, pi);
        e = V_BUSY | ((k == n - 1) ? (V_PC | V_RW | V_CLR) : 10'b0);
        cyc("crypto", e, 1'b1, (k > RMAX) ? RMAX : k, i, pi,
            sel ? (k == done_k) : 1'($urandom % 2));
      end
    end else begin
      e = V_PC | V_CLR;
      if (is_legal(op) && op != O_BR && !mret) e |= V_RW;
      if (csr) e |= V_CSR;
      cyc("exec", e, 1'b0, 0, i, pi, 1'($urandom % 2));
    end
    if (i | pi) begin
      pick(mode, i, pi);
      cyc("inter", V_INT | V_PC | V_CLR, 1'b0, 0, i, pi, 1'($urandom % 2));
    end
  endtask

  task automatic rand_instr(input int done_max);
    logic [6:0] ops [11];
    logic [6:0] op;
    logic [2:0] f3;
    logic [11:0] f12;
    int r;
    ops = '{O_LUI, O_AUIPC, O_JAL, O_JALR, O_BR, O_LOAD, O_STORE, O_OPI, O_OP, O_SYS, O_ENC};
    r = $urandom_range(0, 11);
    if (r < 11) begin
      op = ops[r];
    end else begin
      do op = 7'($urandom); while (is_legal(op));
    end
    f3  = 3'($urandom);
    f12 = ($urandom % 2) ? 12'h302 : 12'($urandom);
    run_instr(op, f3, f12, 0, $urandom_range(0, done_max));
  endtask

  task automatic do_reset();
    CU_RESET_N = 1'b0;
    CU_INT = 1'b0; CU_prevINT = 1'b0; CU_CRYPTO_DONE = 1'b0;
    @(negedge CU_CLK);
    check("reset_out", 32'(obs), 32'(V_MR1));
    check("reset_round", 32'(obs_round), 0);
    @(posedge CU_CLK);
    #1 CU_RESET_N = 1'b1;
  endtask

  initial begin
    // Fixed-round instance.
    sel = 1'b0;
    @(posedge CU_CLK);
    do_reset();
    run_instr(O_OP, 3'b000, 12'h000, 2, 0);
    run_instr(O_LOAD, 3'b010, 12'h000, 1, 0);
    run_instr(O_ENC, 3'b000, 12'h000, 2, 0);
    run_instr(O_SYS, 3'b110, 12'h340, 2, 0);
    run_instr(O_SYS, 3'b000, 12'h302, 2, 0);
    run_instr(7'b1111111, 3'b000, 12'h000, 2, 0);
    run_instr(O_ENC, 3'b000, 12'h000, 1, 0);

    // Asynchronous reset in the third CRYPTO cycle aborts the ENCRY.
    CU_OPCODE = O_ENC;
    cyc("abort_fetch", V_MR1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    cyc("abort_exec", V_START, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    cyc("abort_c0", V_BUSY, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    cyc("abort_c1", V_BUSY, 1'b1, 1, 1'b0, 1'b0, 1'b0);
    @(negedge CU_CLK);
    check("abort_c2_round", 32'(obs_round), 2);
    #2 CU_RESET_N = 1'b0;
    #1;
    check("abort_async_out", 32'(obs), 32'(V_MR1));
    check("abort_async_round", 32'(obs_round), 0);
    @(posedge CU_CLK);
    #1;
    @(negedge CU_CLK);
    check("abort_hold_out", 32'(obs), 32'(V_MR1));
    @(posedge CU_CLK);
    #1 CU_RESET_N = 1'b1;

    for (int n = 0; n < 150; n++) rand_instr(0);

    // Handshake instance.
    sel = 1'b1;
    do_reset();
    run_instr(O_ENC, 3'b000, 12'h000, 1, 7);
    run_instr(O_ENC, 3'b000, 12'h000, 2, 0);
    run_instr(O_ENC, 3'b000, 12'h000, 0, 10);
    run_instr(O_STORE, 3'b010, 12'h000, 1, 0);
    for (int n = 0; n < 150; n++) rand_instr(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/otter_cu_fsm_mc.md
Name: otter_cu_fsm_mc

Overview:
Multi-cycle OTTER control-unit FSM, parametrised successor of the single-cycle-crypto control unit. It sequences FETCH/EXECUTE/WB/INTER like the existing unit. ENCRY instructions run in a dedicated CRYPTO state, either for a parametrised round count or until a coprocessor done handshake. It drives PC, register-file, memory, CSR and interrupt strobes for the OTTER datapath.

Parameters:
CRYPTO_ROUNDS, 4, CRYPTO-state cycles per ENCRY in fixed mode; legal range 1..(2**CNT_W)-1.
CNT_W, 3, round-counter width.
CRYPTO_HANDSHAKE, 0, 0 = fixed round count; 1 = wait for CU_CRYPTO_DONE.

Ports:
CU_CLK  in  1  clock, rising edge.
CU_RESET_N  in  1  asynchronous, active-low reset.
CU_INT  in  1  external interrupt request.
CU_prevINT  in  1  latched pending interrupt.
CU_OPCODE  in  7  IR[6:0].
CU_FUNC3  in  3  IR[14:12].
CU_FUNC12  in  12  IR[31:20].
CU_CRYPTO_DONE  in  1  coprocessor completion; used only when CRYPTO_HANDSHAKE=1.
CU_PCWRITE  out  1  PC update strobe.
CU_REGWRITE  out  1  register-file write enable.
CU_MEMWRITE  out  1  data-memory write.
CU_MEMREAD1  out  1  instruction fetch read.
CU_MEMREAD2  out  1  data-memory read.
CU_intTaken  out  1  interrupt entry.
CU_csrWrite  out  1  CSR write enable.
CU_intCLR  out  1  clear pending-interrupt latch.
CU_CRYPTO_START  out  1  one-cycle coprocessor start pulse.
CU_CRYPTO_ROUND  out  CNT_W  current round index.
CU_BUSY  out  1  high while in CRYPTO.

Behaviour:
- States: FETCH, EXECUTE, CRYPTO, WB, INTER. All outputs are Moore/Mealy-decoded from state and opcode; no output registers except the round counter.
- Reset (CU_RESET_N=0, asynchronous, including mid-CRYPTO):
  - state=FETCH, round=0.
  - Hence CU_MEMREAD1=1 during reset; all other outputs are 0.
  - No PCWRITE may be issued for an aborted instruction.
- Interrupt pending: intp = CU_INT | CU_prevINT.
- MRET: SYSTEM opcode, FUNC3=000, FUNC12=12'h302.
- FETCH: MEMREAD1=1. Next state is EXECUTE unconditionally.
- EXECUTE:
  - LOAD: MEMREAD2=1; next WB.
  - STORE: MEMWRITE=1, PCWRITE=1; next INTER if intp, else FETCH.
  - ENCRY (7'b0011100): CRYPTO_START=1, round cleared to 0; next CRYPTO. No PCWRITE or REGWRITE.
  - Other legal opcodes: PCWRITE=1. REGWRITE=1 unless BRANCH or MRET. Next INTER if intp, else FETCH.
  - csrWrite=1 for SYSTEM with FUNC3 in {001,010,011,101,110,111}. This covers all six CSR variants.
  - Illegal opcode: PCWRITE=1, REGWRITE=0, no memory access; next FETCH or INTER by the same rule.
- CRYPTO:
  - BUSY=1; round increments by 1 each cycle and saturates at all-ones.
  - Last cycle: round==CRYPTO_ROUNDS-1 in fixed mode, or CU_CRYPTO_DONE=1 in handshake mode.
  - In the last cycle: PCWRITE=1, REGWRITE=1; next INTER if intp, else FETCH.
  - Interrupts are never taken mid-CRYPTO; they are deferred to the last cycle.
  - Fixed-mode ENCRY latency is 2+CRYPTO_ROUNDS cycles. With CRYPTO_ROUNDS=1, CRYPTO lasts exactly one cycle.
  - In handshake mode, CRYPTO_DONE is ignored outside CRYPTO. If DONE never arrives, the FSM stays in CRYPTO with round saturated until reset.
- WB: PCWRITE=1, REGWRITE=1; next INTER if intp, else FETCH.
- INTER: intTaken=1, PCWRITE=1; next FETCH.
- CU_intCLR is asserted in every cycle where PCWRITE=1 (instruction retire or INTER).
- CU_OPCODE, CU_FUNC3 and CU_FUNC12 must be stable from EXECUTE through the end of the instruction (IR held by the datapath).

Decomposition:
- Package otter_cu_pkg holds:
  - opcode_t (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, SYSTEM, ENCRY);
  - funct3_system_t;
  - cu_state_t;
  - localparam MRET_FUNC12=12'h302.
- One sub-module, otter_cu_round_ctr: clear, enable, saturating CNT_W counter, and last-round compare against CRYPTO_ROUNDS.

Test Plan:
- Reset release, then OP (7'b0110011): cycle0 MEMREAD1=1; cycle1 PCWRITE=1, REGWRITE=1; cycle2 back in FETCH.
- LOAD with CU_INT=1 during WB: EXECUTE MEMREAD2=1; WB PCWRITE=1, REGWRITE=1, intCLR=1; then INTER with intTaken=1; then FETCH.
- ENCRY with CRYPTO_ROUNDS=4, fixed mode: START pulse in EXECUTE; BUSY high 4 cycles with ROUND=0,1,2,3; PCWRITE and REGWRITE only at ROUND=3; total 6 cycles.
- ENCRY with CRYPTO_HANDSHAKE=1, DONE asserted after 7 CRYPTO cycles, CU_INT=1 throughout: no INTER before DONE; retire in the DONE cycle; next state INTER.
- CU_RESET_N pulled low at ROUND=2 of ENCRY: asynchronous return to FETCH, ROUND=0, BUSY=0, no PCWRITE pulse.
- SYSTEM FUNC3=110 gives csrWrite=1. MRET (FUNC12=12'h302) gives PCWRITE=1, REGWRITE=0. Opcode 7'b1111111 gives PCWRITE=1, REGWRITE=0, MEMWRITE=0.
